// File: rtl/mem_pkg.sv
// Shared codes and types for the MEM stage: funct3 access modes, writeback
// source selects, the request FSM state, and the alignment rule.
package mem_pkg;

    localparam logic [2:0] ADDR_B  = 3'b000;
    localparam logic [2:0] ADDR_H  = 3'b001;
    localparam logic [2:0] ADDR_W  = 3'b010;
    localparam logic [2:0] ADDR_BU = 3'b100;
    localparam logic [2:0] ADDR_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Unlisted funct3 codes are treated as naturally aligned.
    function automatic logic addr_aligned(input logic [2:0] mode, input logic [1:0] a_lo);
        logic ok;
        case (mode)
            ADDR_W:         ok = (a_lo == 2'b00);
            ADDR_H, ADDR_HU: ok = ~a_lo[0];
            default:        ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack port; the MEM stage is the master, memory the slave.
interface mem_access_stage_if #(
    parameter int WIDTH = 32
);
    logic             DMemReq;
    logic             DMemWe;
    logic [WIDTH-1:0] DMemAddr;
    logic [3:0]       DMemBe;
    logic [WIDTH-1:0] DMemWData;
    logic             DMemAck;
    logic [WIDTH-1:0] DMemRData;

    modport master (
        output DMemReq, DMemWe, DMemAddr, DMemBe, DMemWData,
        input  DMemAck, DMemRData
    );

    modport slave (
        input  DMemReq, DMemWe, DMemAddr, DMemBe, DMemWData,
        output DMemAck, DMemRData
    );
endinterface

// File: rtl/mem_access_stage_load_extend.sv
// Load alignment: selects the addressed byte/half from the read word and
// sign- or zero-extends it according to funct3.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  mode_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted_s;

    assign shifted_s = rdata_i >> {addr_lo_i, 3'b000};

    // Extend the shifted lane to a full word.
    always_comb begin
        data_o = shifted_s;
        case (mode_i)
            ADDR_B:  data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            ADDR_H:  data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            ADDR_BU: data_o = {24'h000000, shifted_s[7:0]};
            ADDR_HU: data_o = {16'h0000, shifted_s[15:0]};
            default: data_o = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage and MEM/WB register: issues one registered request per
// aligned load/store, stalls until acknowledged, and forms the WB bundle.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ALUResult_M,
    input  logic [WIDTH-1:0] WriteData_M,
    input  logic [4:0]       Rd_M,
    input  logic [WIDTH-1:0] PCP4_M,
    input  logic             RegWrite_M,
    input  logic             MemRead_M,
    input  logic             MemWrite_M,
    input  logic [1:0]       ResultSrc_M,
    input  logic [2:0]       AddrMode_M,
    output logic             Stall_M,
    mem_access_stage_if.master dmem,
    output logic [WIDTH-1:0] ALUResult_W,
    output logic [WIDTH-1:0] ReadData_W,
    output logic [WIDTH-1:0] PCP4_W,
    output logic [4:0]       Rd_W,
    output logic             RegWrite_W,
    output logic [1:0]       ResultSrc_W,
    output logic             MisAlign_W
);

    mem_state_t       state_q, state_d;
    logic             req_q, req_d, we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [WIDTH-1:0] alu_w_q, alu_w_d, rdata_w_q, rdata_w_d, pcp4_w_q, pcp4_w_d;
    logic [4:0]       rd_w_q, rd_w_d;
    logic             rw_w_q, rw_w_d, mis_w_q, mis_w_d;
    logic [1:0]       rs_w_q, rs_w_d;

    logic [1:0]       a_lo_s;
    logic             mem_op_s, acc_s, misalign_s, stall_s, done_s;
    logic [3:0]       be_s;
    logic [WIDTH-1:0] wdata_s, ext_s;

    assign a_lo_s     = ALUResult_M[1:0];
    assign mem_op_s   = MemRead_M | MemWrite_M;
    assign acc_s      = mem_op_s & addr_aligned(AddrMode_M, a_lo_s);
    assign misalign_s = mem_op_s & ~addr_aligned(AddrMode_M, a_lo_s);

    load_extend u_load_extend (
        .rdata_i  (dmem.DMemRData),
        .addr_lo_i(a_lo_s),
        .mode_i   (AddrMode_M),
        .data_o   (ext_s)
    );

    // Byte enables and lane-replicated store data from funct3 size bits.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = WriteData_M;
        case (AddrMode_M[1:0])
            2'b00: begin
                be_s    = 4'b0001 << a_lo_s;
                wdata_s = {4{WriteData_M[7:0]}};
            end
            2'b01: begin
                be_s    = 4'b0011 << {a_lo_s[1], 1'b0};
                wdata_s = {2{WriteData_M[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = WriteData_M;
            end
        endcase
    end

    // Request FSM: latch the port on issue, hold it until the ack cycle.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        stall_s = 1'b0;
        done_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_s) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    we_d    = MemWrite_M;
                    addr_d  = {ALUResult_M[WIDTH-1:2], 2'b00};
                    be_d    = be_s;
                    wdata_d = wdata_s;
                    stall_s = 1'b1;
                end else begin
                    state_d = IDLE;
                    stall_s = 1'b0;
                end
            end
            WAIT: begin
                if (dmem.DMemAck) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // WB bundle: a bubble while stalled, otherwise the retiring instruction.
    always_comb begin
        alu_w_d   = '0;
        rdata_w_d = '0;
        pcp4_w_d  = '0;
        rd_w_d    = 5'd0;
        rw_w_d    = 1'b0;
        rs_w_d    = 2'b00;
        mis_w_d   = 1'b0;
        if (stall_s) begin
            rw_w_d  = 1'b0;
            mis_w_d = 1'b0;
        end else begin
            alu_w_d   = ALUResult_M;
            pcp4_w_d  = PCP4_M;
            rd_w_d    = Rd_M;
            rs_w_d    = ResultSrc_M;
            rw_w_d    = RegWrite_M & ~misalign_s;
            mis_w_d   = misalign_s;
            rdata_w_d = (done_s & MemRead_M & ~MemWrite_M) ? ext_s : '0;
        end
    end

    // State, memory port and MEM/WB registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            alu_w_q   <= '0;
            rdata_w_q <= '0;
            pcp4_w_q  <= '0;
            rd_w_q    <= 5'd0;
            rw_w_q    <= 1'b0;
            rs_w_q    <= 2'b00;
            mis_w_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            alu_w_q   <= alu_w_d;
            rdata_w_q <= rdata_w_d;
            pcp4_w_q  <= pcp4_w_d;
            rd_w_q    <= rd_w_d;
            rw_w_q    <= rw_w_d;
            rs_w_q    <= rs_w_d;
            mis_w_q   <= mis_w_d;
        end
    end

    assign Stall_M        = stall_s;
    assign dmem.DMemReq   = req_q;
    assign dmem.DMemWe    = we_q;
    assign dmem.DMemAddr  = addr_q;
    assign dmem.DMemBe    = be_q;
    assign dmem.DMemWData = wdata_q;
    assign ALUResult_W    = alu_w_q;
    assign ReadData_W     = rdata_w_q;
    assign PCP4_W         = pcp4_w_q;
    assign Rd_W           = rd_w_q;
    assign RegWrite_W     = rw_w_q;
    assign ResultSrc_W    = rs_w_q;
    assign MisAlign_W     = mis_w_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the driver pushes the expected WB
// bundle per instruction, the monitor pops it when the instruction retires.
module tb_mem_access_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pcp4;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  rs;
        logic        mis;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ALUResult_M = '0, WriteData_M = '0, PCP4_M = '0;
    logic [4:0]  Rd_M = 5'd0;
    logic        RegWrite_M = 1'b0, MemRead_M = 1'b0, MemWrite_M = 1'b0;
    logic [1:0]  ResultSrc_M = 2'b00;
    logic [2:0]  AddrMode_M = 3'b000;
    logic        Stall_M;
    logic [31:0] ALUResult_W, ReadData_W, PCP4_W;
    logic [4:0]  Rd_W;
    logic        RegWrite_W, MisAlign_W;
    logic [1:0]  ResultSrc_W;

    int  total = 0;
    int  bad = 0;
    bit  m_valid = 1'b0;
    bit  mon_en = 1'b0;
    bit  adv;
    wb_t sb[$];

    mem_access_stage_if #(.WIDTH(32)) dmem_bus ();

    mem_access_stage #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUResult_M(ALUResult_M),
        .WriteData_M(WriteData_M),
        .Rd_M       (Rd_M),
        .PCP4_M     (PCP4_M),
        .RegWrite_M (RegWrite_M),
        .MemRead_M  (MemRead_M),
        .MemWrite_M (MemWrite_M),
        .ResultSrc_M(ResultSrc_M),
        .AddrMode_M (AddrMode_M),
        .Stall_M    (Stall_M),
        .dmem       (dmem_bus),
        .ALUResult_W(ALUResult_W),
        .ReadData_W (ReadData_W),
        .PCP4_W     (PCP4_W),
        .Rd_W       (Rd_W),
        .RegWrite_W (RegWrite_W),
        .ResultSrc_W(ResultSrc_W),
        .MisAlign_W (MisAlign_W)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ALUResult_M = '0; WriteData_M = '0; PCP4_M = '0; Rd_M = 5'd0;
        RegWrite_M = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0;
        ResultSrc_M = 2'b00; AddrMode_M = 3'b000;
        m_valid = 1'b0;
    endtask

    // Drive one instruction (called just after a negedge) and play the memory.
    task automatic run_op(input string nm,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pcp4,
                          input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                          input logic [1:0] rs, input logic [2:0] am,
                          input int waits, input logic [31:0] rdata, input int exp_stall,
                          input logic exp_we, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input wb_t exp);
        int stalls = 0;
        int w = 0;
        int guard = 0;
        ALUResult_M = alu; WriteData_M = wd; PCP4_M = pcp4; Rd_M = rd;
        RegWrite_M = rw; MemRead_M = mr; MemWrite_M = mw;
        ResultSrc_M = rs; AddrMode_M = am;
        dmem_bus.DMemAck = 1'b0;
        m_valid = 1'b1;
        sb.push_back(exp);
        #1;
        while (Stall_M && guard < 50) begin
            stalls++;
            guard++;
            @(negedge clk);
            if (dmem_bus.DMemReq) begin
                if (w == waits) begin
                    dmem_bus.DMemAck   = 1'b1;
                    dmem_bus.DMemRData = rdata;
                end else begin
                    w++;
                end
            end
            #1;
        end
        if (guard >= 50) begin
            bad++;
            total++;
            $display("FAIL %s_timeout: stall did not clear within 50 cycles", nm);
        end
        check({nm, "_stall_cycles"}, stalls, exp_stall);
        if (exp_stall > 0) begin
            check({nm, "_req"},  {31'd0, dmem_bus.DMemReq}, 32'd1);
            check({nm, "_we"},   {31'd0, dmem_bus.DMemWe}, {31'd0, exp_we});
            check({nm, "_addr"}, dmem_bus.DMemAddr, exp_addr);
            check({nm, "_be"},   {28'd0, dmem_bus.DMemBe}, {28'd0, exp_be});
            if (exp_we)
                check({nm, "_wdata"}, dmem_bus.DMemWData, exp_wdata);
        end
        @(posedge clk);
        @(negedge clk);
        dmem_bus.DMemAck = 1'b0;
        check({nm, "_req_after"}, {31'd0, dmem_bus.DMemReq}, 32'd0);
    endtask

    // Monitor: decide retirement before the edge, compare WB outputs after it.
    always begin
        @(posedge clk);
        adv = m_valid && !Stall_M && rst_n;
        #1;
        if (adv) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: retirement with empty scoreboard");
            end else begin
                wb_t e;
                e = sb.pop_front();
                check("wb_alu",   ALUResult_W, e.alu);
                check("wb_rdata", ReadData_W,  e.rdata);
                check("wb_pcp4",  PCP4_W,      e.pcp4);
                check("wb_rd",    {27'd0, Rd_W},        {27'd0, e.rd});
                check("wb_rw",    {31'd0, RegWrite_W},  {31'd0, e.rw});
                check("wb_rs",    {30'd0, ResultSrc_W}, {30'd0, e.rs});
                check("wb_mis",   {31'd0, MisAlign_W},  {31'd0, e.mis});
            end
        end else if (mon_en) begin
            check("wb_bubble", {30'd0, RegWrite_W, MisAlign_W}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        dmem_bus.DMemAck   = 1'b0;
        dmem_bus.DMemRData = '0;
        repeat (2) @(negedge clk);
        check("rst_req",   {31'd0, dmem_bus.DMemReq}, 32'd0);
        check("rst_we",    {31'd0, dmem_bus.DMemWe},  32'd0);
        check("rst_be",    {28'd0, dmem_bus.DMemBe},  32'd0);
        check("rst_addr",  dmem_bus.DMemAddr,  32'd0);
        check("rst_wdata", dmem_bus.DMemWData, 32'd0);
        check("rst_stall", {31'd0, Stall_M},   32'd0);
        check("rst_wb",    ALUResult_W | ReadData_W | PCP4_W |
                           {25'd0, Rd_W, RegWrite_W, ResultSrc_W, MisAlign_W}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        run_op("lw",  32'h100, 32'h0, 32'h1004, 5'd5, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010,
               3, 32'hDEADBEEF, 4, 1'b0, 32'h100, 4'b1111, 32'h0,
               '{alu:32'h100, rdata:32'hDEADBEEF, pcp4:32'h1004, rd:5'd5, rw:1'b1, rs:2'b01, mis:1'b0});
        run_op("lb",  32'h103, 32'h0, 32'h1008, 5'd6, 1'b1, 1'b1, 1'b0, 2'b01, 3'b000,
               0, 32'h80123456, 1, 1'b0, 32'h100, 4'b1000, 32'h0,
               '{alu:32'h103, rdata:32'hFFFFFF80, pcp4:32'h1008, rd:5'd6, rw:1'b1, rs:2'b01, mis:1'b0});
        run_op("lbu", 32'h103, 32'h0, 32'h100C, 5'd7, 1'b1, 1'b1, 1'b0, 2'b01, 3'b100,
               0, 32'h80123456, 1, 1'b0, 32'h100, 4'b1000, 32'h0,
               '{alu:32'h103, rdata:32'h00000080, pcp4:32'h100C, rd:5'd7, rw:1'b1, rs:2'b01, mis:1'b0});
        run_op("sh",  32'h102, 32'h1234ABCD, 32'h1010, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001,
               1, 32'h0, 2, 1'b1, 32'h100, 4'b1100, 32'hABCDABCD,
               '{alu:32'h102, rdata:32'h0, pcp4:32'h1010, rd:5'd0, rw:1'b0, rs:2'b00, mis:1'b0});
        run_op("lw_mis", 32'h101, 32'h0, 32'h1014, 5'd8, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010,
               0, 32'h0, 0, 1'b0, 32'h0, 4'b0000, 32'h0,
               '{alu:32'h101, rdata:32'h0, pcp4:32'h1014, rd:5'd8, rw:1'b0, rs:2'b01, mis:1'b1});
        run_op("alu", 32'hCAFEF00D, 32'h0, 32'h1018, 5'd9, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000,
               0, 32'h0, 0, 1'b0, 32'h0, 4'b0000, 32'h0,
               '{alu:32'hCAFEF00D, rdata:32'h0, pcp4:32'h1018, rd:5'd9, rw:1'b1, rs:2'b00, mis:1'b0});
        run_op("lh",  32'h106, 32'h0, 32'h101C, 5'd10, 1'b1, 1'b1, 1'b0, 2'b01, 3'b001,
               1, 32'h80017777, 2, 1'b0, 32'h104, 4'b1100, 32'h0,
               '{alu:32'h106, rdata:32'hFFFF8001, pcp4:32'h101C, rd:5'd10, rw:1'b1, rs:2'b01, mis:1'b0});
        run_op("lhu", 32'h0E2, 32'h0, 32'h1020, 5'd11, 1'b1, 1'b1, 1'b0, 2'b01, 3'b101,
               0, 32'h9ABC1234, 1, 1'b0, 32'h0E0, 4'b1100, 32'h0,
               '{alu:32'h0E2, rdata:32'h00009ABC, pcp4:32'h1020, rd:5'd11, rw:1'b1, rs:2'b01, mis:1'b0});
        run_op("sb",  32'h201, 32'h000000A5, 32'h1024, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000,
               2, 32'h0, 3, 1'b1, 32'h200, 4'b0010, 32'hA5A5A5A5,
               '{alu:32'h201, rdata:32'h0, pcp4:32'h1024, rd:5'd0, rw:1'b0, rs:2'b00, mis:1'b0});
        run_op("rw_both", 32'h300, 32'h11223344, 32'h1028, 5'd0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b010,
               0, 32'h55555555, 1, 1'b1, 32'h300, 4'b1111, 32'h11223344,
               '{alu:32'h300, rdata:32'h0, pcp4:32'h1028, rd:5'd0, rw:1'b0, rs:2'b00, mis:1'b0});
        run_op("jal", 32'h0, 32'h0, 32'h40, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10, 3'b000,
               0, 32'h0, 0, 1'b0, 32'h0, 4'b0000, 32'h0,
               '{alu:32'h0, rdata:32'h0, pcp4:32'h40, rd:5'd1, rw:1'b1, rs:2'b10, mis:1'b0});
        run_op("lh_mis", 32'h103, 32'h0, 32'h102C, 5'd12, 1'b1, 1'b1, 1'b0, 2'b01, 3'b001,
               0, 32'h0, 0, 1'b0, 32'h0, 4'b0000, 32'h0,
               '{alu:32'h103, rdata:32'h0, pcp4:32'h102C, rd:5'd12, rw:1'b0, rs:2'b01, mis:1'b1});
        idle_inputs();
        @(negedge clk);

        // Reset while a load is waiting, then a stray ack afterwards.
        ALUResult_M = 32'h200; MemRead_M = 1'b1; RegWrite_M = 1'b1;
        ResultSrc_M = 2'b01; AddrMode_M = 3'b010; Rd_M = 5'd3;
        @(negedge clk);
        check("rstwait_req_before", {31'd0, dmem_bus.DMemReq}, 32'd1);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rstwait_req_in_rst", {31'd0, dmem_bus.DMemReq}, 32'd0);
        rst_n = 1'b1;
        dmem_bus.DMemAck   = 1'b1;
        dmem_bus.DMemRData = 32'hFFFFFFFF;
        #1;
        check("rstwait_stall_ack", {31'd0, Stall_M}, 32'd0);
        @(negedge clk);
        dmem_bus.DMemAck = 1'b0;
        check("rstwait_req_after", {31'd0, dmem_bus.DMemReq}, 32'd0);
        check("rstwait_rdata_w",   ReadData_W, 32'd0);
        check("rstwait_rw_w",      {31'd0, RegWrite_W}, 32'd0);
        check("rstwait_alu_w",     ALUResult_W, 32'd0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
